// File: rtl/sap_pkg.sv
// Shared constants for the 8-bit microcomputer: control-word bit indices,
// opcodes and a bus-contention helper used by the datapath.
package sap_pkg;

    localparam int CTRL_W = 15;

    localparam int HLT_B = 14;
    localparam int MI_B  = 13;
    localparam int RI_B  = 12;
    localparam int RO_B  = 11;
    localparam int IO_B  = 10;
    localparam int II_B  = 9;
    localparam int AI_B  = 8;
    localparam int AO_B  = 7;
    localparam int SO_B  = 6;
    localparam int SU_B  = 5;
    localparam int BI_B  = 4;
    localparam int OI_B  = 3;
    localparam int CE_B  = 2;
    localparam int CO_B  = 1;
    localparam int J_B   = 0;

    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // True when more than one bit is set: clearing the lowest set bit leaves a residue.
    function automatic logic multi_drv(input logic [4:0] drv);
        return (drv & (drv - 5'd1)) != 5'd0;
    endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational adder/subtractor; subtraction is A + ~B + 1 so carry
// doubles as a no-borrow flag.
module sap_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              su_i,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o
);

    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   sum;

    assign b_op = su_i ? ~b_i : b_i;
    assign sum  = {1'b0, a_i} + {1'b0, b_op} + {{DATA_W{1'b0}}, su_i};

    assign res_o   = sum[DATA_W-1:0];
    assign carry_o = sum[DATA_W];

endmodule

// File: rtl/sap_datapath.sv
// Shared-bus execution datapath: PC, MAR, RAM, IR, A/B, ALU and output
// register, one control word executed per rising edge.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CTRL_W-1:0] ctrl_wrd,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        instruction,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              carry,
    output logic              halted,
    output logic              bus_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic hlt, mi, ri, ro, io, ii, ai, ao, so, su, bi, oi, ce, co, j;

    assign hlt = ctrl_wrd[HLT_B];
    assign mi  = ctrl_wrd[MI_B];
    assign ri  = ctrl_wrd[RI_B];
    assign ro  = ctrl_wrd[RO_B];
    assign io  = ctrl_wrd[IO_B];
    assign ii  = ctrl_wrd[II_B];
    assign ai  = ctrl_wrd[AI_B];
    assign ao  = ctrl_wrd[AO_B];
    assign so  = ctrl_wrd[SO_B];
    assign su  = ctrl_wrd[SU_B];
    assign bi  = ctrl_wrd[BI_B];
    assign oi  = ctrl_wrd[OI_B];
    assign ce  = ctrl_wrd[CE_B];
    assign co  = ctrl_wrd[CO_B];
    assign j   = ctrl_wrd[J_B];

    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic              carry_q, carry_d, halted_q, halted_d;
    logic              bus_err_q, bus_err_d, out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ram_q [DEPTH];

    logic [DATA_W-1:0] bus, alu_res;
    logic              alu_c, ld;

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i    (a_q),
        .b_i    (b_q),
        .su_i   (su),
        .res_o  (alu_res),
        .carry_o(alu_c)
    );

    // Wired-OR bus: contention is flagged, never resolved.
    always_comb begin
        bus = '0;
        if (co) bus = bus | {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        if (ro) bus = bus | ram_q[mar_q];
        if (io) bus = bus | {{(DATA_W-4){1'b0}}, ir_q[3:0]};
        if (ao) bus = bus | a_q;
        if (so) bus = bus | alu_res;
    end

    assign ld = enable & ~halted_q;

    always_comb begin
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        carry_d     = carry_q;
        halted_d    = halted_q;
        bus_err_d   = bus_err_q;
        out_valid_d = out_valid_q;
        if (enable) begin
            bus_err_d   = bus_err_q | multi_drv({co, ro, io, ao, so});
            out_valid_d = ld & oi;
            if (hlt) halted_d = 1'b1;
        end
        if (ld) begin
            if (mi) mar_d = bus[ADDR_W-1:0];
            if (ii) ir_d = bus;
            if (ai) a_d = bus;
            if (ai && so) carry_d = alu_c;
            if (bi) b_d = bus;
            if (oi) out_d = bus;
            if (j) pc_d = bus[ADDR_W-1:0];
            else if (ce) pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            carry_q     <= 1'b0;
            halted_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            carry_q     <= carry_d;
            halted_q    <= halted_d;
            bus_err_q   <= bus_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    // RAM survives reset; the later program-load write wins an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (ld && ri) ram_q[mar_q] <= bus;
            if (prog_we) ram_q[prog_addr] <= prog_data;
        end
    end

    assign instruction = ir_q[7:4];
    assign out_data    = out_q;
    assign out_valid   = out_valid_q;
    assign carry       = carry_q;
    assign halted      = halted_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Bench for sap_datapath: directed program/ALU/bus/halt/reset scenarios
// plus random control words, all checked against a behavioural model.
module tb_sap_datapath;
    import sap_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [14:0] ctrl_wrd = '0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic [3:0]  instruction;
    logic [7:0]  out_data;
    logic        out_valid, carry, halted, bus_err;

    sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ctrl_wrd(ctrl_wrd),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instruction(instruction), .out_data(out_data), .out_valid(out_valid),
        .carry(carry), .halted(halted), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] K_HLT = 15'h4000;
    localparam logic [14:0] K_MI  = 15'h2000;
    localparam logic [14:0] K_RI  = 15'h1000;
    localparam logic [14:0] K_RO  = 15'h0800;
    localparam logic [14:0] K_IO  = 15'h0400;
    localparam logic [14:0] K_II  = 15'h0200;
    localparam logic [14:0] K_AI  = 15'h0100;
    localparam logic [14:0] K_AO  = 15'h0080;
    localparam logic [14:0] K_SO  = 15'h0040;
    localparam logic [14:0] K_SU  = 15'h0020;
    localparam logic [14:0] K_BI  = 15'h0010;
    localparam logic [14:0] K_OI  = 15'h0008;
    localparam logic [14:0] K_CE  = 15'h0004;
    localparam logic [14:0] K_CO  = 15'h0002;
    localparam logic [14:0] K_J   = 15'h0001;

    int m_pc, m_mar, m_ir, m_a, m_b, m_out;
    int m_carry, m_halt, m_berr, m_ov;
    int m_mem [16];
    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference machine: registers as integers, bus as an OR of sources.
    always @(posedge clk) begin : model
        int bus, nd, res, cy;
        if (reset) begin
            m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
            m_carry = 0; m_halt = 0; m_berr = 0; m_ov = 0;
        end else begin
            if (ctrl_wrd[SU_B]) begin
                res = (m_a - m_b + 256) % 256;
                cy  = (m_a >= m_b) ? 1 : 0;
            end else begin
                res = (m_a + m_b) % 256;
                cy  = (m_a + m_b > 255) ? 1 : 0;
            end
            bus = 0; nd = 0;
            if (ctrl_wrd[CO_B]) begin bus |= m_pc; nd++; end
            if (ctrl_wrd[RO_B]) begin bus |= m_mem[m_mar]; nd++; end
            if (ctrl_wrd[IO_B]) begin bus |= m_ir % 16; nd++; end
            if (ctrl_wrd[AO_B]) begin bus |= m_a; nd++; end
            if (ctrl_wrd[SO_B]) begin bus |= res; nd++; end
            if (enable) begin
                if (nd > 1) m_berr = 1;
                m_ov = (ctrl_wrd[OI_B] && m_halt == 0) ? 1 : 0;
            end
            if (enable && m_halt == 0) begin
                if (ctrl_wrd[RI_B]) m_mem[m_mar] = bus;
                if (ctrl_wrd[MI_B]) m_mar = bus % 16;
                if (ctrl_wrd[II_B]) m_ir = bus;
                if (ctrl_wrd[AI_B]) m_a = bus;
                if (ctrl_wrd[AI_B] && ctrl_wrd[SO_B]) m_carry = cy;
                if (ctrl_wrd[BI_B]) m_b = bus;
                if (ctrl_wrd[OI_B]) m_out = bus;
                if (ctrl_wrd[J_B]) m_pc = bus % 16;
                else if (ctrl_wrd[CE_B]) m_pc = (m_pc + 1) % 16;
                if (ctrl_wrd[HLT_B]) m_halt = 1;
            end
            if (prog_we) m_mem[prog_addr] = prog_data;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("instruction", instruction, m_ir / 16);
            chk("out_data", out_data, m_out);
            chk("out_valid", out_valid, m_ov);
            chk("carry", carry, m_carry);
            chk("halted", halted, m_halt);
            chk("bus_err", bus_err, m_berr);
            if (out_valid) pulses++;
        end
    end

    task automatic cyc(input logic [14:0] cw, input bit en, input bit pw,
                       input int pa, input int pd, input bit rst);
        @(negedge clk);
        ctrl_wrd  = cw;
        enable    = en;
        prog_we   = pw;
        prog_addr = 4'(pa);
        prog_data = 8'(pd);
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [14:0] cw);
        cyc(cw, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic goto_pc(input int k);
        while (m_pc != k) step(K_CE);
    endtask

    // Loads A or B with v through RAM[15] addressed via the PC.
    task automatic ld_reg(input int v, input bit to_b);
        cyc('0, 1'b1, 1'b1, 15, v, 1'b0);
        goto_pc(15);
        step(K_CO | K_MI);
        step(K_RO | (to_b ? K_BI : K_AI));
    endtask

    task automatic read_ram(input int addr);
        goto_pc(addr);
        step(K_CO | K_MI);
        step(K_RO | K_OI);
        step('0);
    endtask

    initial begin
        int prog [16];
        logic [14:0] cw;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1;
        chk("rst_out_data", out_data, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_halted", halted, 0);

        prog[0] = 'h1E; prog[1] = 'h2F; prog[2] = 'hE0; prog[3] = 'hF0;
        for (int i = 4; i < 14; i++) prog[i] = int'($urandom_range(0, 255));
        prog[14] = 28; prog[15] = 14;
        for (int i = 0; i < 16; i++) cyc('0, 1'b0, 1'b1, i, prog[i], 1'b0);

        pulses = 0;
        step(K_CO | K_MI); step(K_RO | K_II | K_CE);
        step(K_IO | K_MI); step(K_RO | K_AI);
        step(K_CO | K_MI); step(K_RO | K_II | K_CE);
        step(K_IO | K_MI); step(K_RO | K_BI); step(K_SO | K_AI);
        step(K_CO | K_MI); step(K_RO | K_II | K_CE);
        step(K_AO | K_OI);
        step(K_CO | K_MI); step(K_RO | K_II | K_CE);
        step(K_HLT);
        step('0);
        chk("prog_out", out_data, 42);
        chk("prog_halted", halted, 1);
        chk("prog_pc", dut.pc_q, 4);
        chk("prog_opcode", instruction, OP_HLT);
        chk("prog_pulses", pulses, 1);

        step(K_CO | K_OI | K_CE);
        step(K_AO | K_AI | K_OI);
        cyc(K_AI | K_OI, 1'b1, 1'b1, 3, 'hAA, 1'b0);
        chk("halt_out", out_data, 42);
        chk("halt_pc", dut.pc_q, 4);
        chk("halt_a", dut.a_q, 42);

        cyc('0, 1'b1, 1'b0, 0, 0, 1'b1);
        chk("rst_clears_halt", halted, 0);
        read_ram(3);
        chk("halt_prog_we", out_data, 'hAA);

        ld_reg(5, 0); ld_reg(7, 1);
        step(K_SU | K_SO | K_AI); step(K_AO | K_OI); step('0);
        chk("sub_borrow", out_data, 'hFE);
        chk("sub_borrow_c", carry, 0);
        ld_reg(7, 0); ld_reg(5, 1);
        step(K_SU | K_SO | K_AI); step(K_AO | K_OI); step('0);
        chk("sub_ok", out_data, 'h02);
        chk("sub_ok_c", carry, 1);

        ld_reg('hF0, 0);
        goto_pc(3);
        step(K_AO | K_CO | K_OI);
        chk("conflict_err", bus_err, 1);
        step('0);
        chk("conflict_bus", out_data, 'hF3);
        repeat (3) step(K_CE);
        chk("conflict_sticky", bus_err, 1);
        cyc('0, 1'b1, 1'b0, 0, 0, 1'b1);
        chk("conflict_rst", bus_err, 0);

        goto_pc(15);
        step(K_CE); step(K_CO | K_OI); step('0);
        chk("pc_wrap", out_data, 0);
        ld_reg(9, 0);
        step(K_AO | K_J | K_CE); step(K_CO | K_OI); step('0);
        chk("jump_prio", out_data, 9);

        ld_reg('h33, 0); ld_reg('h11, 1);
        cyc(K_AI | K_SO, 1'b1, 1'b0, 0, 0, 1'b1);
        chk("midrst_halted", halted, 0);
        step(K_AO | K_OI); step('0);
        chk("midrst_a", out_data, 0);
        read_ram(14);
        chk("midrst_ram", out_data, 28);

        for (int n = 0; n < 500; n++) begin
            cw = 15'($urandom);
            if ($urandom_range(0, 39) != 0) cw[HLT_B] = 1'b0;
            cyc(cw, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                $urandom_range(0, 49) == 0);
        end
        step('0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
